button_cmd_sched: RTL and testbench

- Command scheduler that sits behind the per-button debouncers in the scrolling-text design.
- Detects presses on N debounced button levels and, under BTN_AUTOREPEAT_EN, generates hold-to-repeat events.
- Queues one pending event per button and arbitrates them round-robin onto a single valid/ready command port consumed by the display controller.

---
 rtl/button_cmd_sched.sv | 260 ++++++++++++++++++++++++++
 tb/tb_button_cmd_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_cmd_sched.sv
// ---------------------------------------------------------------------------
// button_cmd_sched
//
// Command scheduler behind the per-button debouncers of the scrolling-text
// design. It detects presses on N_BTN debounced levels. When auto-repeat is
// built, it also generates hold-to-repeat events. Each button has one pending
// slot. Pending slots are arbitrated round-robin onto a single valid/ready
// command port.
//
// Optional feature macro: BTN_AUTOREPEAT_EN
//   defined   : tick prescaler, per-button timers and repeat events are built
//   undefined : press events only, cmd_repeat tied to 0
//
// Ports
//   clk         in   rising-edge system clock
//   rst_n       in   asynchronous active-low reset
//   btn_level   in   [N_BTN] debounced button levels, 1 = pressed
//   cmd_valid   out  a command is presented
//   cmd_id      out  [clog2(N_BTN)] index of the button owning the command
//   cmd_repeat  out  0 = initial press, 1 = auto-repeat
//   cmd_ready   in   consumer accepts the command
//   drop_cnt    out  [8] events lost to a full pending slot, saturating
// ---------------------------------------------------------------------------
module button_cmd_sched #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 100000,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_level,
    output logic                     cmd_valid,
    output logic [$clog2(N_BTN)-1:0] cmd_id,
    output logic                     cmd_repeat,
    input  logic                     cmd_ready,
    output logic [7:0]               drop_cnt
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int CNT_W = ID_W + 1;

`ifdef BTN_AUTOREPEAT_EN
    localparam int T_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int T_W   = $clog2(T_MAX + 1);
    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [T_W-1:0] T_HOLD = T_W'(HOLD_TICKS);
    localparam logic [T_W-1:0] T_RPT  = T_W'(REPEAT_TICKS);

    typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;
`else
    typedef enum logic {IDLE, HELD} state_t;
`endif

    // Saturating add for the drop counter; it must stick at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [CNT_W-1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + 9'(b);
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    logic [N_BTN-1:0] prev;
    state_t           state [N_BTN];
    logic [N_BTN-1:0] ev;

`ifdef BTN_AUTOREPEAT_EN
    logic [PS_W-1:0]  ps_cnt;
    logic             tick;
    logic [T_W-1:0]   timer [N_BTN];
    logic [N_BTN-1:0] ev_rep;

    assign tick = (ps_cnt == PS_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end
`endif

    // ---- stage p0: edge detect / hold timing -> event strobes ----
    // A timer at 1 with a tick arriving is the tick on which it reaches 0.
    always_comb begin
        ev = '0;
`ifdef BTN_AUTOREPEAT_EN
        ev_rep = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            case (state[i])
                IDLE: ev[i] = btn_level[i] & ~prev[i];
`ifdef BTN_AUTOREPEAT_EN
                HELD, RPT: begin
                    if (btn_level[i] && tick && (timer[i] <= T_W'(1))) begin
                        ev[i]     = 1'b1;
                        ev_rep[i] = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= IDLE;
`ifdef BTN_AUTOREPEAT_EN
                timer[i] <= '0;
`endif
            end
        end else begin
            prev <= btn_level;
            for (int i = 0; i < N_BTN; i++) begin
                case (state[i])
                    IDLE: begin
                        if (btn_level[i] && !prev[i]) begin
                            state[i] <= HELD;
`ifdef BTN_AUTOREPEAT_EN
                            timer[i] <= T_HOLD;
`endif
                        end
                    end
`ifdef BTN_AUTOREPEAT_EN
                    HELD, RPT: begin
                        // Release wins over a coinciding tick: no event on release.
                        if (!btn_level[i]) begin
                            state[i] <= IDLE;
                            timer[i] <= '0;
                        end else if (tick) begin
                            if (timer[i] <= T_W'(1)) begin
                                state[i] <= RPT;
                                timer[i] <= T_RPT;
                            end else begin
                                timer[i] <= timer[i] - 1'b1;
                            end
                        end
                    end
`else
                    HELD: begin
                        if (!btn_level[i]) begin
                            state[i] <= IDLE;
                        end
                    end
`endif
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

    // ---- stage p1: pending slots and round-robin arbitration ----
    logic [N_BTN-1:0] pend_p1;
`ifdef BTN_AUTOREPEAT_EN
    logic [N_BTN-1:0] prep_p1;
    logic             rep_p2;
`endif
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  next_ptr;
    logic [CNT_W-1:0] probe;
    logic             found;
    logic             load;
    logic [N_BTN-1:0] grant;
    logic [N_BTN-1:0] drop;
    logic [CNT_W-1:0] n_drop;

    // The output register may take a new command when empty or being accepted.
    assign load = !cmd_valid || cmd_ready;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        probe  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            probe = {1'b0, ptr} + CNT_W'(k);
            if (probe >= CNT_W'(N_BTN)) begin
                probe = probe - CNT_W'(N_BTN);
            end
            if (!found && pend_p1[probe[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = probe[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (winner == ID_W'(N_BTN - 1)) ? '0 : winner + 1'b1;

    // A slot granted this cycle is free for a coinciding event, so no drop.
    always_comb begin
        grant = '0;
        if (load && found) begin
            grant[winner] = 1'b1;
        end
        drop   = ev & pend_p1 & ~grant;
        n_drop = '0;
        for (int i = 0; i < N_BTN; i++) begin
            n_drop = n_drop + CNT_W'(drop[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p1 <= '0;
`ifdef BTN_AUTOREPEAT_EN
            prep_p1 <= '0;
`endif
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (ev[i] && !drop[i]) begin
                    pend_p1[i] <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                    prep_p1[i] <= ev_rep[i];
`endif
                end else if (grant[i]) begin
                    pend_p1[i] <= 1'b0;
                end
            end
        end
    end

    // ---- stage p2: registered command port ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
            ptr       <= '0;
            drop_cnt  <= '0;
`ifdef BTN_AUTOREPEAT_EN
            rep_p2    <= 1'b0;
`endif
        end else begin
            drop_cnt <= sat_add8(drop_cnt, n_drop);
            if (load) begin
                if (found) begin
                    cmd_valid <= 1'b1;
                    cmd_id    <= winner;
                    ptr       <= next_ptr;
`ifdef BTN_AUTOREPEAT_EN
                    rep_p2    <= prep_p1[winner];
`endif
                end else begin
                    cmd_valid <= 1'b0;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    assign cmd_repeat = rep_p2;
`else
    assign cmd_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_cmd_sched.sv
module tb_button_cmd_sched;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int HT = 5;
    localparam int RT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_level = '0;
    logic         cmd_ready = 1'b0;
    logic         cmd_valid;
    logic [1:0]   cmd_id;
    logic         cmd_repeat;
    logic [7:0]   drop_cnt;

    int checks = 0;
    int errors = 0;

    button_cmd_sched #(
        .N_BTN(N), .TICK_DIV(TD), .HOLD_TICKS(HT), .REPEAT_TICKS(RT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_level(btn_level),
        .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_repeat(cmd_repeat),
        .cmd_ready(cmd_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural reference: edges since reset give the tick phase, ticks held
    // since the press give the repeat schedule, slots/pointer give ordering.
    int m_cyc;
    bit m_prev [N];
    int m_ht [N];
    bit m_pend [N];
    bit m_prep [N];
    bit m_valid;
    int m_id;
    bit m_rep;
    int m_ptr;
    int m_drop;

    task automatic model_reset();
        m_cyc = 0; m_valid = 0; m_id = 0; m_rep = 0; m_ptr = 0; m_drop = 0;
        for (int i = 0; i < N; i++) begin
            m_prev[i] = 0; m_ht[i] = 0; m_pend[i] = 0; m_prep[i] = 0;
        end
    endtask

    task automatic model_step();
        bit tick;
        bit ev [N];
        bit er [N];
        int g;
        tick = ((m_cyc % TD) == TD - 1);
        m_cyc++;
        for (int i = 0; i < N; i++) begin
            ev[i] = 0; er[i] = 0;
            if (btn_level[i]) begin
                if (!m_prev[i]) begin
                    ev[i] = 1; m_ht[i] = 0;
                end else if (tick) begin
                    m_ht[i]++;
`ifdef BTN_AUTOREPEAT_EN
                    if (m_ht[i] == HT || (m_ht[i] > HT && ((m_ht[i] - HT) % RT) == 0)) begin
                        ev[i] = 1; er[i] = 1;
                    end
`endif
                end
            end else begin
                m_ht[i] = 0;
            end
            m_prev[i] = btn_level[i];
        end
        g = -1;
        if (!m_valid || cmd_ready) begin
            m_valid = 0;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            if (g >= 0) begin
                m_valid = 1; m_id = g; m_rep = m_prep[g]; m_pend[g] = 0;
                m_ptr = (g + 1) % N;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ev[i]) begin
                if (m_pend[i]) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_pend[i] = 1; m_prep[i] = er[i];
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; btn_level = '0; cmd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || cmd_id !== 2'd0 || cmd_repeat !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state got v=%0b id=%0d rep=%0b drop=%0d, want all 0", cmd_valid, cmd_id, cmd_repeat, drop_cnt);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset cmd_valid=%0b want 0", cmd_valid);
        end
    endtask

    task automatic test_single_press();
        int n_hs;
        n_hs = 0;
        do_reset();
        cmd_ready = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        btn_level[2] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (cmd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL press_latency1 cmd_valid=%0b want 0", cmd_valid);
                end
            end
            if (c == 2) begin
                checks++;
                if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || cmd_repeat !== 1'b0) begin
                    errors++;
                    $display("FAIL press_latency2 got v=%0b id=%0d rep=%0b want v=1 id=2 rep=0", cmd_valid, cmd_id, cmd_repeat);
                end
            end
            if (cmd_valid && cmd_ready) n_hs++;
            if (c == 12) btn_level[2] = 1'b0;
        end
        checks++;
        if (n_hs != 1) begin
            errors++;
            $display("FAIL single_press_count got %0d want 1", n_hs);
        end
    endtask

    task automatic test_hold();
        int n_press;
        int n_rep;
        int exp_rep;
        n_press = 0; n_rep = 0;
`ifdef BTN_AUTOREPEAT_EN
        exp_rep = 9;
`else
        exp_rep = 0;
`endif
        do_reset();
        cmd_ready = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        btn_level[1] = 1'b1;
        for (int c = 1; c <= 141; c++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== m_valid || drop_cnt !== 8'(m_drop) ||
                (m_valid && (cmd_id !== 2'(m_id) || cmd_repeat !== m_rep))) begin
                errors++;
                $display("FAIL hold_model t=%0t got v=%0b id=%0d rep=%0b drop=%0d want v=%0b id=%0d rep=%0b drop=%0d",
                         $time, cmd_valid, cmd_id, cmd_repeat, drop_cnt, m_valid, m_id, m_rep, m_drop);
            end
            if (cmd_valid && cmd_ready) begin
                if (cmd_repeat) n_rep++;
                else n_press++;
            end
            if (c == 121) btn_level[1] = 1'b0;
        end
        checks++;
        if (n_press != 1 || n_rep != exp_rep) begin
            errors++;
            $display("FAIL hold_counts got press=%0d rep=%0d want press=1 rep=%0d", n_press, n_rep, exp_rep);
        end
    endtask

    task automatic test_simultaneous();
        int exp_ids [2];
        exp_ids[0] = 1; exp_ids[1] = 3;
        do_reset();
        cmd_ready = 1'b0;
        btn_level = 4'b1011;
        @(negedge clk);
        btn_level = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || cmd_id !== 2'd0 || cmd_repeat !== 1'b0) begin
                errors++;
                $display("FAIL stall_stable c=%0d got v=%0b id=%0d rep=%0b want v=1 id=0 rep=0", c, cmd_valid, cmd_id, cmd_repeat);
            end
        end
        cmd_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || cmd_id !== 2'(exp_ids[j])) begin
                errors++;
                $display("FAIL b2b_order j=%0d got v=%0b id=%0d want v=1 id=%0d", j, cmd_valid, cmd_id, exp_ids[j]);
            end
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain cmd_valid=%0b want 0", cmd_valid);
        end
    endtask

    task automatic test_drop();
        do_reset();
        cmd_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            btn_level[0] = 1'b1;
            @(negedge clk);
            btn_level[0] = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd0 || drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL drop_one got v=%0b id=%0d drop=%0d want v=1 id=0 drop=1", cmd_valid, cmd_id, drop_cnt);
        end
        for (int p = 0; p < 260; p++) begin
            btn_level[0] = 1'b1;
            @(negedge clk);
            btn_level[0] = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate got %0d want 255", drop_cnt);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd0 || cmd_repeat !== 1'b0) begin
            errors++;
            $display("FAIL drop_pending got v=%0b id=%0d rep=%0b want v=1 id=0 rep=0", cmd_valid, cmd_id, cmd_repeat);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_drain got v=%0b drop=%0d want v=0 drop=255", cmd_valid, drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cmd_ready = 1'b0;
        btn_level[2] = 1'b1;
        repeat (2) @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            btn_level[0] = 1'b1;
            @(negedge clk);
            btn_level[0] = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset got v=%0b id=%0d drop=%0d want v=1 id=2 drop=1", cmd_valid, cmd_id, drop_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_id !== 2'd0 || cmd_repeat !== 1'b0 || drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset got v=%0b id=%0d rep=%0b drop=%0d want all 0", cmd_valid, cmd_id, cmd_repeat, drop_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset1 cmd_valid=%0b want 0", cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_id !== 2'd2 || cmd_repeat !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_press got v=%0b id=%0d rep=%0b want v=1 id=2 rep=0", cmd_valid, cmd_id, cmd_repeat);
        end
        btn_level = '0;
    endtask

    task automatic test_fairness();
        int last;
        int n_gr;
        last = N - 1; n_gr = 0;
        do_reset();
        btn_level = 4'hF;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== m_valid || drop_cnt !== 8'(m_drop) ||
                (m_valid && (cmd_id !== 2'(m_id) || cmd_repeat !== m_rep))) begin
                errors++;
                $display("FAIL fair_model t=%0t got v=%0b id=%0d rep=%0b drop=%0d want v=%0b id=%0d rep=%0b drop=%0d",
                         $time, cmd_valid, cmd_id, cmd_repeat, drop_cnt, m_valid, m_id, m_rep, m_drop);
            end
            if (cmd_valid && cmd_ready) begin
                checks++;
                if (cmd_id !== 2'((last + 1) % N)) begin
                    errors++;
                    $display("FAIL fair_order got id=%0d want %0d", cmd_id, (last + 1) % N);
                end
                last = int'(cmd_id);
                n_gr++;
            end
            cmd_ready = ~cmd_ready;
        end
        btn_level = '0;
        checks++;
`ifdef BTN_AUTOREPEAT_EN
        if (n_gr <= N) begin
`else
        if (n_gr != N) begin
`endif
            errors++;
            $display("FAIL fair_count got %0d grants", n_gr);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== m_valid || drop_cnt !== 8'(m_drop) ||
                (m_valid && (cmd_id !== 2'(m_id) || cmd_repeat !== m_rep))) begin
                errors++;
                $display("FAIL rand_model t=%0t got v=%0b id=%0d rep=%0b drop=%0d want v=%0b id=%0d rep=%0b drop=%0d",
                         $time, cmd_valid, cmd_id, cmd_repeat, drop_cnt, m_valid, m_id, m_rep, m_drop);
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) btn_level[i] = ~btn_level[i];
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold();
        test_simultaneous();
        test_drop();
        test_reset_mid();
        test_fairness();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
